// File: rtl/jpeg_block_ingress.sv
// Single-buffered 8x8 block stager in front of jpeg_encoder: fill, pad, then 64-cycle drain burst.
// Optional block counter enabled by defining JPEG_INGRESS_BLKCNT_EN.
module jpeg_block_ingress #(
  parameter int DATA_W  = 24,
  parameter int BLK_PIX = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              enable,
  output logic [DATA_W-1:0] data_out,
  output logic              end_of_file_signal,
  output logic              busy,
  output logic [CNT_W-1:0]  block_count
);
  localparam int PW = $clog2(BLK_PIX);
  localparam logic [PW-1:0] PTR_MAX = PW'(BLK_PIX - 1);

  typedef enum logic [1:0] {IDLE, FILL, PAD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wp, rp;
  logic              last_blk;
  logic [DATA_W-1:0] pad_pix;
  logic [DATA_W-1:0] mem [BLK_PIX];
  logic              accept, wr_en, rd_en;
  logic [DATA_W-1:0] wr_data;

  assign accept = s_valid && s_ready && (state == IDLE || state == FILL);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = s_data;
    rd_en     = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (wp == PTR_MAX)  state_nxt = DRAIN;
          else if (s_last)    state_nxt = PAD;
          else                state_nxt = FILL;
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = pad_pix;
        if (wp == PTR_MAX) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd_en = 1'b1;
        if (rp == PTR_MAX) state_nxt = last_blk ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wp                 <= '0;
      rp                 <= '0;
      last_blk           <= 1'b0;
      pad_pix            <= '0;
      s_ready            <= 1'b0;
      enable             <= 1'b0;
      data_out           <= '0;
      end_of_file_signal <= 1'b0;
    end else begin
      state <= state_nxt;
      // Hold s_ready low through the final enable cycle so it rises only after the burst.
      s_ready <= (state_nxt == IDLE || state_nxt == FILL) && (state != DRAIN);
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      if (accept && s_last) begin
        last_blk <= 1'b1;
        pad_pix  <= s_data;
      end else if (rd_en && rp == PTR_MAX) begin
        last_blk <= 1'b0;
      end
      enable             <= rd_en;
      data_out           <= rd_en ? mem[rp] : '0;
      end_of_file_signal <= rd_en && (rp == '0) && last_blk;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wp] <= wr_data;
  end

`ifdef JPEG_INGRESS_BLKCNT_EN
  logic [CNT_W-1:0] blk_cnt;
  always_ff @(posedge clk) begin
    if (rst)                  blk_cnt <= '0;
    else if (enable && !rd_en) blk_cnt <= blk_cnt + 1'b1;
  end
  assign block_count = blk_cnt;
`else
  assign block_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_jpeg_block_ingress.sv
// Directed + randomized bench for jpeg_block_ingress against a block/pad reference model.
module tb_jpeg_block_ingress;
  localparam int DATA_W = 24;
  localparam int BLK    = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, enable, end_of_file_signal, busy;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  block_count;

  int tests = 0;
  int fails = 0;
  int bc_exp = 0;

  jpeg_block_ingress #(.DATA_W(DATA_W), .BLK_PIX(BLK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .enable(enable), .data_out(data_out),
    .end_of_file_signal(end_of_file_signal), .busy(busy), .block_count(block_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " s_ready"}, 32'(s_ready), 0);
    chk({tag, " enable"}, 32'(enable), 0);
    chk({tag, " data_out"}, 32'(data_out), 0);
    chk({tag, " eof"}, 32'(end_of_file_signal), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " block_count"}, 32'(block_count), 0);
  endtask

  function automatic int exp_count();
`ifdef JPEG_INGRESS_BLKCNT_EN
    return bc_exp % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  // Sends one image; pushy drives garbage with s_valid=1 whenever s_ready=0.
  // abort_at>0 asserts rst on that enable cycle of the first burst.
  task automatic run_image(input logic [DATA_W-1:0] pix[$], input int gap_pct,
                           input bit pushy, input int abort_at, input string tag);
    logic [DATA_W-1:0] exp_d[$];
    bit                exp_e[$];
    logic [DATA_W-1:0] cap_d[$];
    bit                cap_e[$];
    int                runs[$];
    int n, nblk, idx, run, cyc, last_acc, first_en, rdy_bad, post_bad, gap_exp;
    bit prev_en, chk_rdy, done, acc;
    n = pix.size(); nblk = (n + BLK - 1) / BLK;
    idx = 0; run = 0; cyc = 0; last_acc = -1; first_en = -1;
    rdy_bad = 0; post_bad = 0; prev_en = 0; chk_rdy = 0; done = 0;
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < BLK; i++) begin
        exp_d.push_back((b * BLK + i < n) ? pix[b * BLK + i] : pix[n - 1]);
        exp_e.push_back(b == nblk - 1 && i == 0);
      end
    while (!done) begin
      acc = 0;
      if (s_ready && idx < n && $urandom_range(99) >= gap_pct) begin
        s_valid = 1; s_data = pix[idx]; s_last = (idx == n - 1); acc = 1;
      end else if (pushy && !s_ready) begin
        s_valid = 1; s_data = DATA_W'($urandom); s_last = 1'($urandom_range(1));
      end else begin
        s_valid = 0; s_last = 0;
      end
      step(); cyc++;
      if (acc) begin
        idx++;
        if (idx == n) last_acc = cyc;
        chk_rdy = (idx == n) || (idx % BLK == 0);
      end
      if (chk_rdy) begin
        chk({tag, " s_ready low after block accept"}, 32'(s_ready), 0);
        chk_rdy = 0;
      end
      if (enable) begin
        cap_d.push_back(data_out); cap_e.push_back(end_of_file_signal); run++;
        if (s_ready) rdy_bad++;
        if (first_en < 0 && last_acc >= 0) first_en = cyc;
      end else if (prev_en) begin
        runs.push_back(run); run = 0; bc_exp++;
        if (s_ready !== 1'b1) post_bad++;
      end
      if (abort_at > 0 && enable && run == abort_at) begin
        rst = 1; s_valid = 0; s_last = 0;
        step();
        chk_reset_vals({tag, " abort"});
        step();
        chk({tag, " s_ready in reset"}, 32'(s_ready), 0);
        rst = 0; bc_exp = 0;
        return;
      end
      prev_en = enable;
      if (idx == n && !busy && !enable) done = 1;
      if (cyc > 20000) begin
        chk({tag, " timeout"}, 32'(cyc), 0);
        done = 1;
      end
    end
    s_valid = 0; s_last = 0;
    gap_exp = ((n % BLK) != 0 ? BLK - (n % BLK) : 0) + 1;
    chk({tag, " burst count"}, 32'(runs.size()), 32'(nblk));
    foreach (runs[i]) chk($sformatf("%s burst%0d len", tag, i), 32'(runs[i]), BLK);
    chk({tag, " pixel count"}, 32'(cap_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s data[%0d]", tag, i), 32'(cap_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s eof[%0d]", tag, i), 32'(cap_e[i]), 32'(exp_e[i]));
    end
    chk({tag, " last accept to enable"}, 32'(first_en - last_acc), 32'(gap_exp));
    chk({tag, " s_ready high during burst"}, 32'(rdy_bad), 0);
    chk({tag, " s_ready not back after burst"}, 32'(post_bad), 0);
    chk({tag, " busy at end"}, 32'(busy), 0);
    chk({tag, " block_count"}, 32'(block_count), 32'(exp_count()));
  endtask

  initial begin
    logic [DATA_W-1:0] q[$];
    rst = 1;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 0;
    step();
    chk("post-reset s_ready", 32'(s_ready), 1);
    chk("post-reset busy", 32'(busy), 0);

    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(DATA_W'(i));
    run_image(q, 0, 1'b1, 0, "ramp64");

    q.delete();
    for (int i = 0; i < 128; i++) q.push_back(DATA_W'($urandom));
    run_image(q, 30, 1'b0, 0, "rand128");

    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(DATA_W'(24'h112233 + i));
    run_image(q, 0, 1'b0, 0, "pad10");

    q.delete();
    q.push_back(24'hABCDEF);
    run_image(q, 0, 1'b0, 0, "single");

    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(DATA_W'($urandom));
    run_image(q, 0, 1'b0, 20, "abort");
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(DATA_W'(24'h500000 + i));
    run_image(q, 10, 1'b0, 0, "after-abort");

    q.delete();
    for (int i = 0; i < 128; i++) q.push_back(DATA_W'($urandom));
    run_image(q, 20, 1'b1, 0, "pushy128");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
